lsu_exec: RTL
=============

Name: lsu_exec

Overview:
- Receiver end of the issue→LSU handshake: takes the load/store uop, base operand and store data from the issue stage.
- Computes the effective address and runs one data-memory transaction on a req/gnt/rvalid bus.
- Returns aligned, sign/zero-extended load data on a registered writeback/forwarding port.
- Back-pressures issue with o_stall while a transaction is in flight; single outstanding access, in order.

Parameters:
- MAX_WAIT, 255: cycles allowed in WAIT_RESP before o_bus_err; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- i_flush  in  1  pipeline flush
- i_valid  in  1  issue offers a uop (issue-side m_valid)
- i_uop  in  uop_t  uop; fields used: opcode (LOAD/STORE), rd, imm, funct3
- i_pc  in  32  uop PC (debug/error reporting)
- i_addr_base  in  32  rs1 operand
- i_store_data  in  32  rs2 operand
- o_stall  out  1  back-pressure to issue (issue-side s_stall_from_lsu)
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  1=store
- o_dmem_addr  out  32  word-aligned address, bits[1:0]=0
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  lane-shifted store data
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  32  load word
- o_wb_valid  out  1  load result valid, 1-cycle pulse; also drives forwarding valid
- o_wb_rd  out  5  destination register
- o_wb_data  out  32  extended load data
- o_misaligned  out  1  misaligned-access pulse
- o_bus_err  out  1  response-timeout pulse
- o_err_pc  out  32  PC of the faulting uop

Behaviour:
- Accept when i_valid && state==IDLE && !i_flush: latch ea=i_addr_base+i_uop.imm (mod 2^32), rd, funct3, is_store, store data, pc.
- o_stall = (state!=IDLE). It is low in the accept cycle, so issue may advance.
- States:
  - IDLE: →REQ on accept.
  - REQ: o_dmem_req=1, all bus outputs stable until gnt. On gnt: store→IDLE, load→WAIT_RESP.
  - WAIT_RESP: on rvalid→IDLE and register the writeback.
  - DRAIN: flushed load awaiting its response; on rvalid→IDLE, no writeback.
- Sizes by funct3:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
  - be: B=1<<ea[1:0], H=3<<ea[1:0], W=4'hF.
  - wdata: byte/half replicated across lanes.
  - Load: shift rdata right by 8*ea[1:0], then sign/zero-extend.
- Min latency: store accept N, req N+1 (gnt same cycle), IDLE N+2. Load accept N, req/gnt N+1, rvalid N+2, o_wb_valid N+3.
- rd==0 load: bus access performed, o_wb_valid suppressed.
- Flush:
  - In REQ before gnt: drop the request, →IDLE next cycle; a store is not performed.
  - Same cycle as gnt: the grant is honoured; a store completes, a load goes to DRAIN.
  - In WAIT_RESP: →DRAIN.
  - Flush never blocks acceptance in the following cycle.
- Watchdog: counter counts cycles in WAIT_RESP/DRAIN. On reaching MAX_WAIT: pulse o_bus_err with o_err_pc, →IDLE, no writeback; a late rvalid in IDLE is ignored.
- Reset: state IDLE, counter 0. All outputs 0 (o_stall, o_dmem_*, o_wb_*, o_misaligned, o_bus_err, o_err_pc). Any in-flight bus transaction is abandoned.
- rvalid/gnt outside the expected state are ignored.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned accesses (H with ea[0]=1, W with ea[1:0]!=0) issue no bus request. One cycle after accept, o_misaligned pulses with o_err_pc; state returns IDLE; no writeback.
- Undefined: low address bits are forced aligned (H clears bit 0, W clears bits[1:0]) and the access proceeds; o_misaligned tied 0.

Decomposition:
- riscv_uop_pkg gains lsu_state_e (IDLE, REQ, WAIT_RESP, DRAIN) and funct3 constants LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
- One sub-module: lsu_align, combinational. Inputs ea[1:0], funct3, store data, rdata. Outputs be, wdata, load result.

Test Plan:
- SW base 0x1000, imm 8, data 0xDEADBEEF, gnt immediate → addr 0x1008, be 4'hF, we=1; o_stall high exactly 1 cycle.
- LB ea 0x2003, rdata 0x80112233, rd=5 → o_wb_data 0xFFFFFF80 at N+3; LBU same → 0x00000080.
- SH ea 0x2002, data 0x0000ABCD → be 4'b1100, wdata 0xABCDABCD.
- LW, gnt delayed 3 cycles, then flush in WAIT_RESP, rvalid 2 cycles later → no o_wb_valid; next LSU uop accepted the cycle after rvalid.
- MAX_WAIT=4, LW granted, no rvalid → o_bus_err pulse 4 cycles after entering WAIT_RESP, o_err_pc = uop PC, o_stall drops.
- LW ea 0x3001: with LSU_MISALIGN_TRAP_EN → o_misaligned pulse, o_dmem_req never set; without the macro → o_dmem_addr 0x3000, normal load.

Source files
------------

// File: rtl/riscv_uop_pkg.sv
// Shared uop bundle, LSU states and access-size codes.
// Used by lsu_exec and lsu_align.
package riscv_uop_pkg;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_BRANCH,
        OP_LOAD,
        OP_STORE,
        OP_SYS
    } op_e;

    typedef struct packed {
        op_e         opcode;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
    } uop_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DRAIN
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == LSU_H) || (f3 == LSU_HU);
    endfunction

    function automatic logic lsu_misaligned(
        input logic [31:0] ea,
        input logic [2:0]  f3
    );
        return (is_half(f3) && ea[0]) ||
               ((f3 == LSU_W) && (ea[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] lsu_force_align(
        input logic [31:0] ea,
        input logic [2:0]  f3
    );
        logic [31:0] r;
        r = ea;
        if (is_half(f3))
            r[0] = 1'b0;
        else if (f3 == LSU_W)
            r[1:0] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/data and load
// extraction with sign or zero extension.
module lsu_align
    import riscv_uop_pkg::*;
(
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [31:0] sh;

    // lane decode per access size
    always_comb begin
        sh    = rdata >> {ea_lo, 3'b000};
        be    = 4'hF;
        wdata = sdata;
        ldata = sh;
        case (funct3)
            LSU_B: begin
                be    = 4'b0001 << ea_lo;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{sh[7]}}, sh[7:0]};
            end
            LSU_BU: begin
                be    = 4'b0001 << ea_lo;
                wdata = {4{sdata[7:0]}};
                ldata = {24'h0, sh[7:0]};
            end
            LSU_H: begin
                be    = 4'b0011 << ea_lo;
                wdata = {2{sdata[15:0]}};
                ldata = {{16{sh[15]}}, sh[15:0]};
            end
            LSU_HU: begin
                be    = 4'b0011 << ea_lo;
                wdata = {2{sdata[15:0]}};
                ldata = {16'h0, sh[15:0]};
            end
            default: begin
                be    = 4'hF;
                wdata = sdata;
                ldata = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_exec.sv
// Load/store execute unit: one outstanding req/gnt/rvalid access.
// Build option LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses.
module lsu_exec
    import riscv_uop_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_valid,
    input  uop_t        i_uop,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_addr_base,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic [31:0] o_err_pc
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    lsu_state_e state, state_d;

    logic [31:0] ea_q, sd_q, pc_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic        st_q;
    logic [CW-1:0] cnt;

    logic [31:0] ea_raw, ea_acc;
    logic        accept, mis, go;
    logic        wd_hit, timeout, wb_fire;

    logic [3:0]  be_a;
    logic [31:0] wd_a, ld_a;

    assign ea_raw = i_addr_base + i_uop.imm;
    assign accept = i_valid && (state == IDLE) && !i_flush;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis    = lsu_misaligned(ea_raw, i_uop.funct3);
    assign ea_acc = ea_raw;
`else
    assign mis    = 1'b0;
    assign ea_acc = lsu_force_align(ea_raw, i_uop.funct3);
`endif

    assign go     = accept && !mis;
    assign wd_hit = (MAX_WAIT != 0) && (cnt == CW'(MAX_WAIT - 1));

    assign o_stall      = (state != IDLE);
    assign o_dmem_req   = (state == REQ);
    assign o_dmem_we    = o_dmem_req && st_q;
    assign o_dmem_addr  = o_dmem_req ? {ea_q[31:2], 2'b00} : 32'h0;
    assign o_dmem_be    = o_dmem_req ? be_a : 4'h0;
    assign o_dmem_wdata = o_dmem_req ? wd_a : 32'h0;

    lsu_align u_align (
        .ea_lo  (ea_q[1:0]),
        .funct3 (f3_q),
        .sdata  (sd_q),
        .rdata  (i_dmem_rdata),
        .be     (be_a),
        .wdata  (wd_a),
        .ldata  (ld_a)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // next state, writeback and timeout decode
    always_comb begin
        state_d = state;
        timeout = 1'b0;
        wb_fire = 1'b0;
        unique case (state)
            IDLE: begin
                if (go)
                    state_d = REQ;
            end
            REQ: begin
                if (i_dmem_gnt) begin
                    if (st_q)
                        state_d = IDLE;
                    else if (i_flush)
                        state_d = DRAIN;
                    else
                        state_d = WAIT_RESP;
                end else if (i_flush) begin
                    state_d = IDLE;
                end
            end
            WAIT_RESP: begin
                if (i_dmem_rvalid) begin
                    state_d = IDLE;
                    wb_fire = !i_flush && (rd_q != 5'd0);
                end else if (wd_hit) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end else if (i_flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_dmem_rvalid) begin
                    state_d = IDLE;
                end else if (wd_hit) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
            end
        endcase
    end

    // latch the accepted uop
    always_ff @(posedge clk) begin
        if (rst) begin
            ea_q <= 32'h0;
            sd_q <= 32'h0;
            pc_q <= 32'h0;
            rd_q <= 5'd0;
            f3_q <= 3'd0;
            st_q <= 1'b0;
        end else if (go) begin
            ea_q <= ea_acc;
            sd_q <= i_store_data;
            pc_q <= i_pc;
            rd_q <= i_uop.rd;
            f3_q <= i_uop.funct3;
            st_q <= (i_uop.opcode == OP_STORE);
        end
    end

    // response watchdog, restarts on each entry to the wait states
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if ((state == WAIT_RESP) || (state == DRAIN))
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    // registered writeback and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            o_wb_valid   <= 1'b0;
            o_wb_rd      <= 5'd0;
            o_wb_data    <= 32'h0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_err_pc     <= 32'h0;
        end else begin
            o_wb_valid   <= wb_fire;
            o_misaligned <= accept && mis;
            o_bus_err    <= timeout;
            if (wb_fire) begin
                o_wb_rd   <= rd_q;
                o_wb_data <= ld_a;
            end
            if (timeout)
                o_err_pc <= pc_q;
            else if (accept && mis)
                o_err_pc <= i_pc;
        end
    end

endmodule
